// File: rtl/sort_stream_if.sv
// Record streams around sort_stream: keyed records in, sorted records out,
// plus the per-frame sort direction.
interface sort_stream_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_key;
    logic [TAG_W-1:0] in_tag;
    logic             descend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_key;
    logic [TAG_W-1:0] out_tag;
    logic             out_last;

    modport master (
        output in_valid, in_key, in_tag, descend, out_ready,
        input  in_ready, out_valid, out_key, out_tag, out_last
    );

    modport slave (
        input  in_valid, in_key, in_tag, descend, out_ready,
        output in_ready, out_valid, out_key, out_tag, out_last
    );
endinterface

// File: rtl/sort_stream.sv
// Frame sorter: loads SIZE key+tag records, sorts them stably with odd-even
// transposition (early exit on two clean phases), then drains them in order.
module sort_stream #(
    parameter  int SIZE   = 8,
    parameter  int WIDTH  = 32,
    parameter  int TAG_W  = 8,
    parameter  int SIGNED = 0,
    localparam int CW     = $clog2(SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    sort_stream_if.slave  bus,
    output logic          busy,
    output logic [CW-1:0] phases
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_e;

    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_key_q [SIZE];
    logic [WIDTH-1:0] reg_key_d [SIZE];
    logic [TAG_W-1:0] reg_tag_q [SIZE];
    logic [TAG_W-1:0] reg_tag_d [SIZE];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    phases_q, phases_d;
    logic             ord_q, ord_d;
    logic             swap_prev_q, swap_prev_d;
    logic             swap_now;
    logic             in_hs;
    logic             out_hs;

    function automatic logic key_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    assign in_hs  = bus.in_valid && (state_q == S_LOAD);
    assign out_hs = bus.out_ready && (state_q == S_DRAIN);

    // NOTE: every _d gets its default first so no path leaves a latch behind;
    // blocking assignments are correct here because this block is purely combinational.
    always_comb begin
        state_d     = state_q;
        reg_key_d   = reg_key_q;
        reg_tag_d   = reg_tag_q;
        cnt_d       = cnt_q;
        phases_d    = phases_q;
        ord_d       = ord_q;
        swap_prev_d = swap_prev_q;
        swap_now    = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (in_hs) begin
                    for (int i = 0; i < SIZE - 1; i++) begin
                        reg_key_d[i] = reg_key_q[i+1];
                        reg_tag_d[i] = reg_tag_q[i+1];
                    end
                    reg_key_d[SIZE-1] = bus.in_key;
                    reg_tag_d[SIZE-1] = bus.in_tag;
                    if (cnt_q == '0) begin
                        ord_d = bus.descend;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_SORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_SORT: begin
                // Pairs start at even indices on even phases, odd indices on odd
                // phases; pairs are disjoint, so each register has one writer.
                for (int i = 0; i < SIZE - 1; i++) begin
                    if ((i % 2) == int'(cnt_q[0])) begin
                        if (ord_q ? key_gt(reg_key_q[i+1], reg_key_q[i])
                                  : key_gt(reg_key_q[i], reg_key_q[i+1])) begin
                            reg_key_d[i]   = reg_key_q[i+1];
                            reg_key_d[i+1] = reg_key_q[i];
                            reg_tag_d[i]   = reg_tag_q[i+1];
                            reg_tag_d[i+1] = reg_tag_q[i];
                            swap_now       = 1'b1;
                        end
                    end
                end
                swap_prev_d = swap_now;
                if (((cnt_q != '0) && !swap_now && !swap_prev_q) || (cnt_q == LAST)) begin
                    phases_d = cnt_q + 1'b1;
                    cnt_d    = '0;
                    state_d  = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                if (out_hs) begin
                    for (int i = 0; i < SIZE - 1; i++) begin
                        reg_key_d[i] = reg_key_q[i+1];
                        reg_tag_d[i] = reg_tag_q[i+1];
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: the record storage is reset along with the control state because
    // out_key/out_tag are read straight from slot 0 and must show zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            phases_q    <= '0;
            ord_q       <= 1'b0;
            swap_prev_q <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                reg_key_q[i] <= '0;
                reg_tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phases_q    <= phases_d;
            ord_q       <= ord_d;
            swap_prev_q <= swap_prev_d;
            reg_key_q   <= reg_key_d;
            reg_tag_q   <= reg_tag_d;
        end
    end

    assign bus.in_ready  = (state_q == S_LOAD) && rst_n;
    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.out_key   = reg_key_q[0];
    assign bus.out_tag   = reg_tag_q[0];
    assign bus.out_last  = (state_q == S_DRAIN) && (cnt_q == LAST);
    assign busy          = (state_q != S_LOAD);
    assign phases        = phases_q;

endmodule

// File: tb/tb_sort_stream.sv
// Bench for sort_stream: an unsigned and a signed instance, driven with directed
// and random frames and compared against a stable-sort reference model.
module tb_sort_stream;

    localparam int SIZE  = 8;
    localparam int WIDTH = 8;
    localparam int TAG_W = 8;
    localparam int CW    = $clog2(SIZE + 1);

    typedef struct packed {
        logic [WIDTH-1:0] key;
        logic [TAG_W-1:0] tag;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_stream_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus_u ();
    sort_stream_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus_s ();

    logic          busy_u, busy_s;
    logic [CW-1:0] phases_u, phases_s;

    sort_stream #(.SIZE(SIZE), .WIDTH(WIDTH), .TAG_W(TAG_W), .SIGNED(0)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_u),
        .busy   (busy_u),
        .phases (phases_u)
    );

    sort_stream #(.SIZE(SIZE), .WIDTH(WIDTH), .TAG_W(TAG_W), .SIGNED(1)) u_dut_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_s),
        .busy   (busy_s),
        .phases (phases_s)
    );

    // Index 0 = unsigned instance, 1 = signed instance.
    logic             drv_valid [2];
    logic             drv_ready [2];
    logic             drv_desc  [2];
    logic [WIDTH-1:0] drv_key   [2];
    logic [TAG_W-1:0] drv_tag   [2];

    logic             obs_in_ready  [2];
    logic             obs_out_valid [2];
    logic             obs_out_last  [2];
    logic [WIDTH-1:0] obs_out_key   [2];
    logic [TAG_W-1:0] obs_out_tag   [2];
    logic             obs_busy      [2];
    logic [CW-1:0]    obs_phases    [2];

    assign bus_u.in_valid  = drv_valid[0];
    assign bus_u.out_ready = drv_ready[0];
    assign bus_u.descend   = drv_desc[0];
    assign bus_u.in_key    = drv_key[0];
    assign bus_u.in_tag    = drv_tag[0];
    assign bus_s.in_valid  = drv_valid[1];
    assign bus_s.out_ready = drv_ready[1];
    assign bus_s.descend   = drv_desc[1];
    assign bus_s.in_key    = drv_key[1];
    assign bus_s.in_tag    = drv_tag[1];

    assign obs_in_ready[0]  = bus_u.in_ready;
    assign obs_out_valid[0] = bus_u.out_valid;
    assign obs_out_last[0]  = bus_u.out_last;
    assign obs_out_key[0]   = bus_u.out_key;
    assign obs_out_tag[0]   = bus_u.out_tag;
    assign obs_busy[0]      = busy_u;
    assign obs_phases[0]    = phases_u;
    assign obs_in_ready[1]  = bus_s.in_ready;
    assign obs_out_valid[1] = bus_s.out_valid;
    assign obs_out_last[1]  = bus_s.out_last;
    assign obs_out_key[1]   = bus_s.out_key;
    assign obs_out_tag[1]   = bus_s.out_tag;
    assign obs_busy[1]      = busy_s;
    assign obs_phases[1]    = phases_s;

    rec_t frame_in [SIZE];
    rec_t exp_out  [SIZE];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int key_val(input logic [WIDTH-1:0] k, input bit sgn);
        if (sgn) return int'($signed(k));
        return int'(k);
    endfunction

    function automatic bit goes_first(input rec_t a, input rec_t b, input bit desc, input bit sgn);
        int ka;
        int kb;
        ka = key_val(a.key, sgn);
        kb = key_val(b.key, sgn);
        return desc ? (ka > kb) : (ka < kb);
    endfunction

    // Expected output order by stable insertion sort; expected phase count by
    // sweeping the arrival-ordered keys until two consecutive clean sweeps.
    task automatic build_model(input bit desc, input bit sgn, output int p);
        rec_t tmp [SIZE];
        int   k   [SIZE];
        int   j;
        int   t;
        bit   any;
        bit   prev_any;
        for (int i = 0; i < SIZE; i++) begin
            j = i;
            while (j > 0 && goes_first(frame_in[i], tmp[j-1], desc, sgn)) begin
                tmp[j] = tmp[j-1];
                j--;
            end
            tmp[j] = frame_in[i];
        end
        for (int i = 0; i < SIZE; i++) exp_out[i] = tmp[i];
        for (int i = 0; i < SIZE; i++) begin
            k[i] = key_val(frame_in[i].key, sgn);
            if (desc) k[i] = -k[i];
        end
        p        = SIZE;
        prev_any = 1'b1;
        for (int ph = 0; ph < SIZE; ph++) begin
            any = 1'b0;
            for (int i = ph % 2; i + 1 < SIZE; i += 2) begin
                if (k[i] > k[i+1]) begin
                    t = k[i]; k[i] = k[i+1]; k[i+1] = t;
                    any = 1'b1;
                end
            end
            if (ph >= 1 && !any && !prev_any) begin
                p = ph + 1;
                break;
            end
            prev_any = any;
        end
    endtask

    task automatic fill_random(input int range);
        for (int i = 0; i < SIZE; i++) begin
            frame_in[i].key = WIDTH'($urandom_range(range));
            frame_in[i].tag = TAG_W'(i);
        end
    endtask

    // Loads frame_in into instance d, waits out the sort, then consumes `take`
    // outputs with random stalls. lat = cycles from the last accept to out_valid.
    task automatic run_frame(input int d, input bit desc, input int gap_pct, input int stall_pct,
                             input int take, input string name, output int lat);
        int               p_exp;
        int               idx;
        int               guard;
        int               n;
        bit               held;
        logic [WIDTH-1:0] hold_key;
        logic [TAG_W-1:0] hold_tag;
        build_model(desc, d == 1, p_exp);
        idx   = 0;
        guard = 0;
        lat   = 0;
        while (idx < SIZE && guard < 2000) begin
            @(negedge clk);
            guard++;
            drv_ready[d] = 1'b0;
            if (int'($urandom_range(99)) < gap_pct) begin
                drv_valid[d] = 1'b0;
                drv_key[d]   = WIDTH'($urandom);
            end else begin
                drv_valid[d] = 1'b1;
                drv_key[d]   = frame_in[idx].key;
                drv_tag[d]   = frame_in[idx].tag;
                drv_desc[d]  = (idx == 0) ? desc : ~desc;
                if (obs_in_ready[d]) idx++;
            end
        end
        n_checks++;
        if (idx != SIZE) $display("FAIL %s load: accepted %0d records, want %0d", name, idx, SIZE);

        // Junk on the input side while busy must be ignored.
        do begin
            @(negedge clk);
            lat++;
            drv_valid[d] = 1'b1;
            drv_key[d]   = WIDTH'($urandom);
            drv_desc[d]  = ~desc;
            if (lat == 1) begin
                n_checks++;
                if (obs_in_ready[d] !== 1'b0 || obs_busy[d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s sort entry: in_ready=%b busy=%b, want 0 1", name,
                             obs_in_ready[d], obs_busy[d]);
                end
            end
        end while (!obs_out_valid[d] && lat < 4 * SIZE);
        n_checks++;
        if (lat != p_exp + 1) begin
            n_fail++;
            $display("FAIL %s latency: out_valid after %0d cycles, want %0d", name, lat, p_exp + 1);
        end
        if (n_checks > 0 && idx != SIZE) n_fail++;

        n     = 0;
        held  = 1'b0;
        guard = 0;
        while (obs_out_valid[d] === 1'b1 && n < take && guard < 2000) begin
            if (guard != 0) @(negedge clk);
            guard++;
            n_checks++;
            if (obs_out_valid[d] !== 1'b1 || obs_in_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s drain flags at out %0d: out_valid=%b in_ready=%b, want 1 0", name,
                         n, obs_out_valid[d], obs_in_ready[d]);
                break;
            end
            if (held) begin
                n_checks++;
                if (obs_out_key[d] !== hold_key || obs_out_tag[d] !== hold_tag) begin
                    n_fail++;
                    $display("FAIL %s stall hold: key=%0h tag=%0h, want key=%0h tag=%0h", name,
                             obs_out_key[d], obs_out_tag[d], hold_key, hold_tag);
                end
            end
            drv_valid[d] = 1'b1;
            drv_key[d]   = WIDTH'($urandom);
            if (int'($urandom_range(99)) < stall_pct) begin
                drv_ready[d] = 1'b0;
                held         = 1'b1;
                hold_key     = obs_out_key[d];
                hold_tag     = obs_out_tag[d];
            end else begin
                drv_ready[d] = 1'b1;
                held         = 1'b0;
                n_checks++;
                if (obs_out_key[d] !== exp_out[n].key || obs_out_tag[d] !== exp_out[n].tag ||
                    obs_out_last[d] !== (n == SIZE - 1)) begin
                    n_fail++;
                    $display("FAIL %s out[%0d]: key=%0h tag=%0h last=%b, want key=%0h tag=%0h last=%b",
                             name, n, obs_out_key[d], obs_out_tag[d], obs_out_last[d],
                             exp_out[n].key, exp_out[n].tag, (n == SIZE - 1));
                end
                n++;
            end
        end
        n_checks++;
        if (n != take) begin
            n_fail++;
            $display("FAIL %s drain count: got %0d outputs, want %0d", name, n, take);
        end

        if (take == SIZE) begin
            @(negedge clk);
            drv_valid[d] = 1'b0;
            drv_ready[d] = 1'b0;
            n_checks++;
            if (obs_out_valid[d] !== 1'b0 || obs_in_ready[d] !== 1'b1 || obs_busy[d] !== 1'b0 ||
                obs_phases[d] !== CW'(p_exp)) begin
                n_fail++;
                $display("FAIL %s frame end: out_valid=%b in_ready=%b busy=%b phases=%0d, want 0 1 0 %0d",
                         name, obs_out_valid[d], obs_in_ready[d], obs_busy[d], obs_phases[d], p_exp);
            end
        end
    endtask

    task automatic test_reset(input string name);
        @(negedge clk);
        rst_n     = 1'b0;
        drv_valid = '{default: 1'b0};
        drv_ready = '{default: 1'b0};
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_in_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s in_ready during reset (dut %0d): %b, want 0", name, d, obs_in_ready[d]);
            end
            n_checks++;
            if (obs_out_valid[d] !== 1'b0 || obs_out_last[d] !== 1'b0 || obs_busy[d] !== 1'b0 ||
                obs_out_key[d] !== '0 || obs_out_tag[d] !== '0 || obs_phases[d] !== '0) begin
                n_fail++;
                $display("FAIL %s reset outputs (dut %0d): valid=%b last=%b busy=%b key=%0h tag=%0h phases=%0d, want all 0",
                         name, d, obs_out_valid[d], obs_out_last[d], obs_busy[d], obs_out_key[d],
                         obs_out_tag[d], obs_phases[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_in_ready[d] !== 1'b1 || obs_out_valid[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after release (dut %0d): in_ready=%b out_valid=%b, want 1 0", name, d,
                         obs_in_ready[d], obs_out_valid[d]);
            end
        end
    endtask

    task automatic test_reverse;
        int lat;
        for (int i = 0; i < SIZE; i++) begin
            frame_in[i].key = WIDTH'(SIZE - i);
            frame_in[i].tag = TAG_W'(i);
        end
        run_frame(0, 1'b0, 0, 0, SIZE, "reverse", lat);
        n_checks++;
        if (obs_phases[0] !== CW'(8)) begin
            n_fail++;
            $display("FAIL reverse phases: %0d, want 8", obs_phases[0]);
        end
    endtask

    task automatic test_sorted;
        int lat;
        for (int i = 0; i < SIZE; i++) begin
            frame_in[i].key = WIDTH'(i + 1);
            frame_in[i].tag = TAG_W'(i);
        end
        run_frame(0, 1'b0, 0, 0, SIZE, "sorted", lat);
        n_checks++;
        if (obs_phases[0] !== CW'(2) || lat != 3) begin
            n_fail++;
            $display("FAIL sorted early exit: phases=%0d latency=%0d, want 2 3", obs_phases[0], lat);
        end
    endtask

    task automatic test_stability;
        int lat;
        for (int i = 0; i < SIZE; i++) begin
            frame_in[i].key = (i % 2 == 0) ? WIDTH'(5) : WIDTH'(3);
            frame_in[i].tag = TAG_W'(i);
        end
        run_frame(0, 1'b0, 0, 0, SIZE, "stability", lat);
    endtask

    task automatic test_signed;
        int               lat;
        logic [WIDTH-1:0] keys [SIZE];
        keys = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'h03, 8'hFD, 8'h40, 8'h01};
        for (int i = 0; i < SIZE; i++) begin
            frame_in[i].key = keys[i];
            frame_in[i].tag = TAG_W'(i);
        end
        run_frame(1, 1'b1, 0, 0, SIZE, "signed descend", lat);
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int f = 0; f < 3; f++) begin
            fill_random(15);
            run_frame(0, 1'($urandom_range(1)), 30, 50, SIZE, "b2b unsigned", lat);
        end
        for (int f = 0; f < 2; f++) begin
            fill_random(255);
            run_frame(1, 1'($urandom_range(1)), 30, 50, SIZE, "b2b signed", lat);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        fill_random(255);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drv_valid[0] = 1'b1;
            drv_key[0]   = frame_in[i].key;
            drv_tag[0]   = frame_in[i].tag;
            drv_desc[0]  = 1'b0;
        end
        test_reset("partial load");
        for (int i = 0; i < 3 * SIZE; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_out_valid[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL partial load residue: out_valid=%b, want 0", obs_out_valid[0]);
                break;
            end
        end
        fill_random(255);
        run_frame(0, 1'b0, 20, 30, SIZE, "after partial reset", lat);

        fill_random(255);
        run_frame(0, 1'b1, 0, 40, 3, "drain aborted", lat);
        test_reset("during drain");
        for (int i = 0; i < 2 * SIZE; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_out_valid[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL drain residue: out_valid=%b, want 0", obs_out_valid[0]);
                break;
            end
        end
        fill_random(255);
        run_frame(0, 1'b1, 20, 30, SIZE, "after drain reset", lat);
    endtask

    initial begin
        drv_valid = '{default: 1'b0};
        drv_ready = '{default: 1'b0};
        drv_desc  = '{default: 1'b0};
        drv_key   = '{default: '0};
        drv_tag   = '{default: '0};
        repeat (2) @(negedge clk);
        test_reset("power-on");
        test_reverse();
        test_sorted();
        test_stability();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
